// File: rtl/wb_stage_pkg.sv
// Shared widths, write-enable encodings, load funct3 codes and FSM state
// encoding for the writeback stage.
package wb_stage_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int GPR_ADDR_WIDTH = 5;

    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load-data extraction: selects the byte/half/word addressed
// by the offset, extends it, and flags misaligned or illegal load types.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{offset, 3'b000} +: 8];
    assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'h0, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = |offset;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results into the GPR write port and holds
// loads in WAIT_LOAD until the data bus acknowledges, then aligns and writes.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    input  logic                      mem_rd_we,
    input  logic [GPR_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                      mem_is_load,
    input  logic [2:0]                mem_funct3,
    input  logic [1:0]                mem_addr_lo,
    input  logic [WORD_WIDTH-1:0]     mem_alu_result,
    input  logic [WORD_WIDTH-1:0]     dbus_rdata,
    input  logic                      dbus_ack,
    input  logic                      flush,
    output logic                      wb_ready,
    output logic                      we_,
    output logic [GPR_ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0]     wr_data,
    output logic                      load_pending,
    output logic [GPR_ADDR_WIDTH-1:0] pending_rd,
    output logic                      load_err
);

    wb_state_e                 state_q, state_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                off_q, off_d;
    logic [GPR_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      we_q, we_d;
    logic [GPR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                      err_q, err_d;

    logic                      accept;
    logic [WORD_WIDTH-1:0]     load_data;
    logic                      load_misaligned;

    load_align u_load_align (
        .rdata      (dbus_rdata),
        .funct3     (funct3_q),
        .offset     (off_q),
        .data       (load_data),
        .misaligned (load_misaligned)
    );

    assign wb_ready = (state_q == IDLE);
    assign accept   = mem_valid & wb_ready & ~flush;

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
        rd_d      = rd_q;
        we_d      = READ;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mem_is_load) begin
                        state_d  = WAIT_LOAD;
                        funct3_d = mem_funct3;
                        off_d    = mem_addr_lo;
                        rd_d     = mem_rd_addr;
                    end else if (mem_rd_we && (mem_rd_addr != '0)) begin
                        we_d      = WRITE;
                        wr_addr_d = mem_rd_addr;
                        wr_data_d = mem_alu_result;
                    end
                end
            end
            WAIT_LOAD: begin
                // flush has priority over a same-cycle ack
                if (flush) begin
                    state_d = IDLE;
                end else if (dbus_ack) begin
                    state_d = IDLE;
                    if (load_misaligned) begin
                        err_d = 1'b1;
                    end else if (rd_q != '0) begin
                        we_d      = WRITE;
                        wr_addr_d = rd_q;
                        wr_data_d = load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state values come from the comb block above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            we_q      <= READ;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign we_          = we_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign load_err     = err_q;
    assign load_pending = (state_q == WAIT_LOAD);
    assign pending_rd   = load_pending ? rd_q : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: a vector table of single
// ALU/load transactions plus hand-written multi-cycle corner sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_rd_we, mem_is_load;
    logic [4:0]  mem_rd_addr;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result, dbus_rdata;
    logic        dbus_ack, flush;
    logic        wb_ready, we_, load_pending, load_err;
    logic [4:0]  wr_addr, pending_rd;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_rd_we      (mem_rd_we),
        .mem_rd_addr    (mem_rd_addr),
        .mem_is_load    (mem_is_load),
        .mem_funct3     (mem_funct3),
        .mem_addr_lo    (mem_addr_lo),
        .mem_alu_result (mem_alu_result),
        .dbus_rdata     (dbus_rdata),
        .dbus_ack       (dbus_ack),
        .flush          (flush),
        .wb_ready       (wb_ready),
        .we_            (we_),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .load_pending   (load_pending),
        .pending_rd     (pending_rd),
        .load_err       (load_err)
    );

    typedef struct {
        string       name;
        logic        is_load;
        logic        rd_we;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        exp_we_n;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic is_load, input logic rd_we, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu);
        mem_valid      = 1'b1;
        mem_is_load    = is_load;
        mem_rd_we      = rd_we;
        mem_rd_addr    = rd;
        mem_funct3     = f3;
        mem_addr_lo    = off;
        mem_alu_result = alu;
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_rd_we = 1'b0; mem_is_load = 1'b0;
        mem_rd_addr = '0; mem_funct3 = '0; mem_addr_lo = '0;
        mem_alu_result = '0; dbus_rdata = '0; dbus_ack = 1'b0; flush = 1'b0;

        vecs[0]  = '{"alu_rd5",    1'b0, 1'b1, 5'd5,  3'b000, 2'd0, 32'h1234_5678, 32'h0,         1'b0, 32'h1234_5678, 1'b0};
        vecs[1]  = '{"alu_x0",     1'b0, 1'b1, 5'd0,  3'b000, 2'd0, 32'hCAFE_0001, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[2]  = '{"alu_no_we",  1'b0, 1'b0, 5'd3,  3'b000, 2'd0, 32'hCAFE_0002, 32'h0,         1'b1, 32'h0,         1'b0};
        vecs[3]  = '{"lb_off3",    1'b1, 1'b1, 5'd7,  3'b000, 2'd3, 32'h0,         32'h80FF_FFFF, 1'b0, 32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{"lbu_off1",   1'b1, 1'b1, 5'd8,  3'b100, 2'd1, 32'h0,         32'h0000_A500, 1'b0, 32'h0000_00A5, 1'b0};
        vecs[5]  = '{"lh_off0",    1'b1, 1'b1, 5'd9,  3'b001, 2'd0, 32'h0,         32'h1234_8001, 1'b0, 32'hFFFF_8001, 1'b0};
        vecs[6]  = '{"lhu_off2",   1'b1, 1'b1, 5'd10, 3'b101, 2'd2, 32'h0,         32'h8001_0000, 1'b0, 32'h0000_8001, 1'b0};
        vecs[7]  = '{"lw_off0",    1'b1, 1'b1, 5'd11, 3'b010, 2'd0, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{"lw_off1",    1'b1, 1'b1, 5'd11, 3'b010, 2'd1, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'h0,         1'b1};
        vecs[9]  = '{"lh_off1",    1'b1, 1'b1, 5'd12, 3'b001, 2'd1, 32'h0,         32'h1111_2222, 1'b1, 32'h0,         1'b1};
        vecs[10] = '{"illegal_f3", 1'b1, 1'b1, 5'd12, 3'b011, 2'd0, 32'h0,         32'h1111_2222, 1'b1, 32'h0,         1'b1};
        vecs[11] = '{"lb_x0",      1'b1, 1'b1, 5'd0,  3'b000, 2'd0, 32'h0,         32'h0000_007F, 1'b1, 32'h0,         1'b0};
        vecs[12] = '{"lb_off2",    1'b1, 1'b1, 5'd12, 3'b000, 2'd2, 32'h0,         32'h0055_0000, 1'b0, 32'h0000_0055, 1'b0};

        // reset values
        #2;
        check("rst_we_n",    {31'h0, we_}, 32'h1);
        check("rst_addr",    {27'h0, wr_addr}, 32'h0);
        check("rst_data",    wr_data, 32'h0);
        check("rst_pending", {31'h0, load_pending}, 32'h0);
        check("rst_prd",     {27'h0, pending_rd}, 32'h0);
        check("rst_err",     {31'h0, load_err}, 32'h0);
        check("rst_ready",   {31'h0, wb_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            offer(vecs[i].is_load, vecs[i].rd_we, vecs[i].rd, vecs[i].f3, vecs[i].off, vecs[i].alu);
            tick();
            mem_valid = 1'b0;
            if (!vecs[i].is_load) begin
                check({vecs[i].name, "_we_n"}, {31'h0, we_}, {31'h0, vecs[i].exp_we_n});
                if (!vecs[i].exp_we_n) begin
                    check({vecs[i].name, "_addr"}, {27'h0, wr_addr}, {27'h0, vecs[i].rd});
                    check({vecs[i].name, "_data"}, wr_data, vecs[i].exp_data);
                end
            end else begin
                check({vecs[i].name, "_pending"}, {31'h0, load_pending}, 32'h1);
                check({vecs[i].name, "_busy"},    {31'h0, wb_ready}, 32'h0);
                check({vecs[i].name, "_prd"},     {27'h0, pending_rd}, {27'h0, vecs[i].rd});
                check({vecs[i].name, "_wait_we"}, {31'h0, we_}, 32'h1);
                dbus_ack   = 1'b1;
                dbus_rdata = vecs[i].rdata;
                tick();
                dbus_ack = 1'b0;
                check({vecs[i].name, "_we_n"}, {31'h0, we_}, {31'h0, vecs[i].exp_we_n});
                if (!vecs[i].exp_we_n) begin
                    check({vecs[i].name, "_addr"}, {27'h0, wr_addr}, {27'h0, vecs[i].rd});
                    check({vecs[i].name, "_data"}, wr_data, vecs[i].exp_data);
                end
                check({vecs[i].name, "_err"},   {31'h0, load_err}, {31'h0, vecs[i].exp_err});
                check({vecs[i].name, "_ready"}, {31'h0, wb_ready}, 32'h1);
            end
            tick();
            check({vecs[i].name, "_we_n_after"}, {31'h0, we_}, 32'h1);
            check({vecs[i].name, "_err_after"},  {31'h0, load_err}, 32'h0);
        end

        // LB with the ack two cycles after accept; stage stays busy meanwhile
        offer(1'b1, 1'b1, 5'd7, 3'b000, 2'd3, 32'h0);
        tick();
        mem_valid = 1'b0;
        check("lb_wait1_ready", {31'h0, wb_ready}, 32'h0);
        tick();
        check("lb_wait2_ready", {31'h0, wb_ready}, 32'h0);
        dbus_ack = 1'b1; dbus_rdata = 32'h80FF_FFFF;
        tick();
        dbus_ack = 1'b0;
        check("lb_late_data", wr_data, 32'hFFFF_FF80);
        check("lb_late_we_n", {31'h0, we_}, 32'h0);
        tick();

        // ack while idle is ignored
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        tick();
        dbus_ack = 1'b0;
        check("idle_ack_we_n",  {31'h0, we_}, 32'h1);
        check("idle_ack_ready", {31'h0, wb_ready}, 32'h1);

        // offer during flush is not accepted
        offer(1'b0, 1'b1, 5'd4, 3'b000, 2'd0, 32'h4444_4444);
        flush = 1'b1;
        tick();
        mem_valid = 1'b0; flush = 1'b0;
        check("flush_offer_we_n", {31'h0, we_}, 32'h1);

        // flush and ack together in WAIT_LOAD: flush wins
        offer(1'b1, 1'b1, 5'd6, 3'b010, 2'd0, 32'h0);
        tick();
        mem_valid = 1'b0;
        flush = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h6666_6666;
        tick();
        flush = 1'b0; dbus_ack = 1'b0;
        check("flush_ack_we_n",    {31'h0, we_}, 32'h1);
        check("flush_ack_err",     {31'h0, load_err}, 32'h0);
        check("flush_ack_ready",   {31'h0, wb_ready}, 32'h1);
        check("flush_ack_pending", {31'h0, load_pending}, 32'h0);
        tick();
        check("flush_ack_we_n2",   {31'h0, we_}, 32'h1);

        // back-to-back: ALU accepted in the cycle the load writes
        offer(1'b1, 1'b1, 5'd14, 3'b010, 2'd0, 32'h0);
        tick();
        mem_valid = 1'b0;
        dbus_ack = 1'b1; dbus_rdata = 32'hA5A5_0001;
        tick();
        dbus_ack = 1'b0;
        check("b2b_load_we_n",  {31'h0, we_}, 32'h0);
        check("b2b_load_addr",  {27'h0, wr_addr}, 32'd14);
        check("b2b_ready",      {31'h0, wb_ready}, 32'h1);
        offer(1'b0, 1'b1, 5'd15, 3'b000, 2'd0, 32'h0BAD_F00D);
        tick();
        mem_valid = 1'b0;
        check("b2b_alu_we_n", {31'h0, we_}, 32'h0);
        check("b2b_alu_addr", {27'h0, wr_addr}, 32'd15);
        check("b2b_alu_data", wr_data, 32'h0BAD_F00D);
        tick();
        check("b2b_idle_we_n", {31'h0, we_}, 32'h1);

        // reset during WAIT_LOAD abandons the load
        offer(1'b1, 1'b1, 5'd13, 3'b010, 2'd0, 32'h0);
        tick();
        mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_we_n",    {31'h0, we_}, 32'h1);
        check("midrst_addr",    {27'h0, wr_addr}, 32'h0);
        check("midrst_data",    wr_data, 32'h0);
        check("midrst_pending", {31'h0, load_pending}, 32'h0);
        check("midrst_prd",     {27'h0, pending_rd}, 32'h0);
        check("midrst_ready",   {31'h0, wb_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        dbus_ack = 1'b1; dbus_rdata = 32'h1313_1313;
        tick();
        dbus_ack = 1'b0;
        check("postrst_ack_we_n", {31'h0, we_}, 32'h1);
        check("postrst_ack_data", wr_data, 32'h0);
        check("postrst_ack_err",  {31'h0, load_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
